// File: rtl/qracc_pkg.sv
// Shared definitions for the QR-ACC macro controller: FSM state encoding and ADC decode offset.
package qracc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR   = 3'd1;
  localparam state_t ST_MRST = 3'd2;
  localparam state_t ST_MDRV = 3'd3;
  localparam state_t ST_MSMP = 3'd4;
  localparam state_t ST_OUT  = 3'd5;

  // Thermometer popcount is re-centred around zero by this offset.
  function automatic int decode_offset(input int adc_bits);
    return 1 << (adc_bits - 1);
  endfunction

endpackage

// File: rtl/qracc_therm_dec.sv
// Per-column ADC thermometer decoder: signed popcount value, plus a bubble flag
// when QRACC_BUBBLE_CHECK_EN is defined.
module qracc_therm_dec
  import qracc_pkg::*;
#(
  parameter int numAdcBits = 4
) (
  input  logic [2**numAdcBits-2:0] therm,
`ifdef QRACC_BUBBLE_CHECK_EN
  output logic                     bubble,
`endif
  output logic [numAdcBits-1:0]    value
);

  int ones;

  always_comb begin
    ones = 0;
    for (int i = 0; i < 2**numAdcBits-1; i++) begin
      ones = ones + int'(therm[i]);
    end
  end

  assign value = numAdcBits'(ones - decode_offset(numAdcBits));

`ifdef QRACC_BUBBLE_CHECK_EN
  // Any non-monotonic code has at least one adjacent 0-below-1 pair.
  always_comb begin
    bubble = 1'b0;
    for (int i = 0; i < 2**numAdcBits-2; i++) begin
      if (therm[i+1] && !therm[i]) bubble = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/qracc_ctrl.sv
// QR-ACC macro controller: weight writes and ternary MAC sequencing with ADC readout.
// Optional res_err bubble flags are enabled by defining QRACC_BUBBLE_CHECK_EN.
module qracc_ctrl
  import qracc_pkg::*;
#(
  parameter int numRows    = 128,
  parameter int numCols    = 8,
  parameter int numAdcBits = 4
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [$clog2(numRows)-1:0]              wr_addr,
  input  logic [numCols-1:0]                      wr_data,
  input  logic                                    mac_valid,
  output logic                                    mac_ready,
  input  logic [numRows-1:0]                      mac_pos,
  input  logic [numRows-1:0]                      mac_neg,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [numCols*numAdcBits-1:0]           res_data,
`ifdef QRACC_BUBBLE_CHECK_EN
  output logic [numCols-1:0]                      res_err,
`endif
  output logic [numRows-1:0]                      WL,
  output logic                                    PCH,
  output logic                                    WRITE,
  output logic [numCols-1:0]                      WR_DATA,
  output logic [numCols-1:0]                      CSEL,
  output logic                                    SAEN,
  output logic [numRows-1:0]                      VDR_SEL,
  output logic [numRows-1:0]                      VDR_SELB,
  output logic [numRows-1:0]                      VSS_SEL,
  output logic [numRows-1:0]                      VSS_SELB,
  output logic [numRows-1:0]                      VRST_SEL,
  output logic [numRows-1:0]                      VRST_SELB,
  output logic                                    NF,
  output logic                                    NFB,
  output logic                                    M2A,
  output logic                                    M2AB,
  output logic                                    R2A,
  output logic                                    R2AB,
  input  logic [(2**numAdcBits-1)*numCols-1:0]    ADC_OUT
);

  localparam int compCount = 2**numAdcBits - 1;

  state_t                          state_reg, state_next;
  logic [$clog2(numRows)-1:0]      wr_addr_reg;
  logic [numCols-1:0]              wr_data_reg;
  logic [numRows-1:0]              pos_reg, neg_reg;
  logic [numCols*numAdcBits-1:0]   res_data_reg, dec_data;
  logic                            in_idle, in_wr, in_drive, wr_fire, mac_fire;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_wr    = (state_reg == ST_WR);
  assign in_drive = (state_reg == ST_MDRV) || (state_reg == ST_MSMP);
  assign wr_fire  = in_idle && wr_valid;
  assign mac_fire = in_idle && !wr_valid && mac_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wr_fire)       state_next = ST_WR;
        else if (mac_fire) state_next = ST_MRST;
      end
      ST_WR:   state_next = ST_IDLE;
      ST_MRST: state_next = ST_MDRV;
      ST_MDRV: state_next = ST_MSMP;
      ST_MSMP: state_next = ST_OUT;
      ST_OUT:  if (res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      pos_reg      <= '0;
      neg_reg      <= '0;
      res_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (wr_fire) begin
        wr_addr_reg <= wr_addr;
        wr_data_reg <= wr_data;
      end
      if (mac_fire) begin
        pos_reg <= mac_pos;
        neg_reg <= mac_neg;
      end
      if (state_reg == ST_MSMP) res_data_reg <= dec_data;
    end
  end

`ifdef QRACC_BUBBLE_CHECK_EN
  logic [numCols-1:0] dec_err, res_err_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                       res_err_reg <= '0;
    else if (state_reg == ST_MSMP) res_err_reg <= dec_err;
  end

  assign res_err = res_err_reg;
`endif

  for (genvar gi = 0; gi < numCols; gi++) begin : g_col
    qracc_therm_dec #(.numAdcBits(numAdcBits)) u_dec (
      .therm (ADC_OUT[gi*compCount +: compCount]),
`ifdef QRACC_BUBBLE_CHECK_EN
      .bubble(dec_err[gi]),
`endif
      .value (dec_data[gi*numAdcBits +: numAdcBits])
    );
  end

  // Ready is gated by RST so nothing looks acceptable while reset is held.
  assign wr_ready  = in_idle && !RST;
  assign mac_ready = in_idle && !wr_valid && !RST;
  assign res_valid = (state_reg == ST_OUT);
  assign res_data  = res_data_reg;

  assign PCH      = in_wr;
  assign WRITE    = in_wr;
  assign WL       = in_wr ? (numRows'(1) << wr_addr_reg) : '0;
  assign WR_DATA  = in_wr ? wr_data_reg : '0;
  assign CSEL     = '0;
  assign SAEN     = 1'b0;

  // Conflicting rows (both +1 and -1 requested) are left undriven.
  assign VDR_SEL  = in_drive ? (pos_reg & ~neg_reg) : '0;
  assign VSS_SEL  = in_drive ? (neg_reg & ~pos_reg) : '0;
  assign VRST_SEL = {numRows{state_reg == ST_MRST}};
  assign R2A      = (state_reg == ST_MRST);
  assign M2A      = (state_reg == ST_MDRV);
  assign NF       = (state_reg == ST_MSMP);

  assign VDR_SELB  = ~VDR_SEL;
  assign VSS_SELB  = ~VSS_SEL;
  assign VRST_SELB = ~VRST_SEL;
  assign NFB       = ~NF;
  assign M2AB      = ~M2A;
  assign R2AB      = ~R2A;

endmodule
